// File: rtl/ibex_pkg.sv
// Shared types for the instruction-bus arbiter slice.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package ibex_pkg;

  // Requesters that can own the shared instruction bus.
  typedef enum logic {
    ARB_SRC_FETCH = 1'b0,
    ARB_SRC_AUX   = 1'b1
  } arb_src_e;

  // Upper bound on granted-but-unanswered requests the arbiter can track.
  localparam int unsigned ARB_MAX_OUTSTANDING_LIMIT = 4;

  // The requester that is not s; used to hand contention to the other side.
  function automatic arb_src_e arb_other_src(arb_src_e s);
    return (s == ARB_SRC_FETCH) ? ARB_SRC_AUX : ARB_SRC_FETCH;
  endfunction

endpackage

// File: rtl/ibex_instr_arb_id_fifo.sv
// Outstanding-ID queue: remembers which requester owns each granted, unanswered request.
// Latency: push visible at head one cycle later; head is read combinationally.
// Backpressure: full_o blocks pushes, empty_o blocks pops; gated requests are dropped.
module ibex_instr_arb_id_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  arb_src_e push_id_i,
  input  logic     pop_i,
  output arb_src_e head_id_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] PtrMax  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  arb_src_e        mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push;
  logic            do_pop;

  assign full_o    = (cnt_q == CntFull);
  assign empty_o   = (cnt_q == '0);
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;
  assign head_id_o = mem_q[rd_ptr_q];

  // Storage and write pointer advance on every accepted push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= ARB_SRC_FETCH;
      end
      wr_ptr_q <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_id_i;
      wr_ptr_q        <= (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + PtrW'(1);
    end
  end

  // Read pointer advances on every accepted pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
    end else if (do_pop) begin
      rd_ptr_q <= (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + PtrW'(1);
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ibex_instr_bus_arbiter.sv
// Two-requester arbiter (fetch, aux) for the shared instruction bus; policy set by IBEX_INSTR_ARB_ROUND_ROBIN_EN.
// Latency: req/addr/gnt and rvalid/rdata/err are all combinational pass-through (zero cycles).
// Backpressure: an ungranted request locks the selection; issue stalls once MaxOutstanding are in flight.
module ibex_instr_bus_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_req_i,
  input  logic [31:0] fetch_addr_i,
  output logic        fetch_gnt_o,
  output logic        fetch_rvalid_o,
  input  logic        aux_req_i,
  input  logic [31:0] aux_addr_i,
  output logic        aux_gnt_o,
  output logic        aux_rvalid_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o
);

  arb_src_e    sel_q;
  arb_src_e    sel_d;
  logic        lock_q;
  logic        lock_d;
  logic        sel_req;
  logic [31:0] sel_addr;
  logic        grant;
  logic        resp;
  logic        fifo_full;
  logic        fifo_empty;
  arb_src_e    head_id;

`ifdef IBEX_INSTR_ARB_ROUND_ROBIN_EN
  // Requester granted most recently; contention goes to the other one.
  arb_src_e    rr_q;
`endif

  // Pick the owner of the bus this cycle; a stalled owner keeps it.
  always_comb begin
    sel_d = sel_q;
    if (lock_q) begin
      sel_d = sel_q;
    end else if (fetch_req_i && !aux_req_i) begin
      sel_d = ARB_SRC_FETCH;
    end else if (!fetch_req_i && aux_req_i) begin
      sel_d = ARB_SRC_AUX;
    end else if (fetch_req_i && aux_req_i) begin
`ifdef IBEX_INSTR_ARB_ROUND_ROBIN_EN
      sel_d = arb_other_src(rr_q);
`else
      sel_d = ARB_SRC_FETCH;
`endif
    end
  end

  // Route the selected requester onto the bus and fan responses back out.
  always_comb begin
    sel_req        = (sel_d == ARB_SRC_FETCH) ? fetch_req_i  : aux_req_i;
    sel_addr       = (sel_d == ARB_SRC_FETCH) ? fetch_addr_i : aux_addr_i;
    // Full means MaxOutstanding in flight; a same-cycle rvalid does not free a slot early.
    instr_req_o    = sel_req & ~fifo_full;
    instr_addr_o   = instr_req_o ? sel_addr : 32'h0;
    grant          = instr_req_o & instr_gnt_i;
    fetch_gnt_o    = grant & (sel_d == ARB_SRC_FETCH);
    aux_gnt_o      = grant & (sel_d == ARB_SRC_AUX);
    // A response with nothing outstanding is dropped.
    resp           = instr_rvalid_i & ~fifo_empty;
    fetch_rvalid_o = resp & (head_id == ARB_SRC_FETCH);
    aux_rvalid_o   = resp & (head_id == ARB_SRC_AUX);
    rdata_o        = instr_rdata_i;
    err_o          = instr_err_i;
    busy_o         = ~fifo_empty | instr_req_o;
    // Lock on an unanswered request, release on grant, otherwise hold (covers full-stall).
    if (grant) begin
      lock_d = 1'b0;
    end else if (instr_req_o) begin
      lock_d = 1'b1;
    end else begin
      lock_d = lock_q;
    end
  end

  // Selection and lock state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q  <= ARB_SRC_FETCH;
      lock_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      lock_q <= lock_d;
    end
  end

`ifdef IBEX_INSTR_ARB_ROUND_ROBIN_EN
  // Remember who won the last grant for fairness on the next contention.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= ARB_SRC_FETCH;
    end else if (grant) begin
      rr_q <= sel_d;
    end
  end
`endif

  ibex_instr_arb_id_fifo #(
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (grant),
    .push_id_i (sel_d),
    .pop_i     (instr_rvalid_i),
    .head_id_o (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

`ifndef SYNTHESIS
  // A requester left waiting must keep its request and address steady.
  a_locked_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> (sel_req && (sel_addr == $past(sel_addr))))
    else $error("locked requester changed req or address");

  // Responses must match an outstanding request; strays are ignored by the logic.
  a_rvalid_has_id: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_i |-> !fifo_empty)
    else $warning("stray instr_rvalid_i ignored: no outstanding ID");

  // Only one requester may be granted at a time.
  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fetch_gnt_o && aux_gnt_o))
    else $error("both grants high");
`endif

endmodule

// File: tb/tb_ibex_instr_bus_arbiter.sv
// Directed bench for the instruction-bus arbiter with an in-order response scoreboard.
// Latency: checks combinational outputs mid-cycle, state effects on the following cycle.
// Backpressure: exercises grant stalls, lock hold and MaxOutstanding saturation.
module tb_ibex_instr_bus_arbiter;
  import ibex_pkg::*;

`ifdef IBEX_INSTR_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // Issued-source encoding used by the stimulus tables.
  localparam logic [1:0] IS_NONE = 2'd0;
  localparam logic [1:0] IS_F    = 2'd1;
  localparam logic [1:0] IS_A    = 2'd2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        fetch_req_i, aux_req_i;
  logic [31:0] fetch_addr_i, aux_addr_i;
  logic        fetch_gnt_o, fetch_rvalid_o, aux_gnt_o, aux_rvalid_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i, instr_rvalid_i, instr_err_i;
  logic [31:0] instr_rdata_i;
  logic [31:0] rdata_o;
  logic        err_o, busy_o;

  int n_chk = 0;
  int n_bad = 0;
  arb_src_e exp_q[$];

  ibex_instr_bus_arbiter #(.MaxOutstanding(2)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .fetch_req_i    (fetch_req_i),
    .fetch_addr_i   (fetch_addr_i),
    .fetch_gnt_o    (fetch_gnt_o),
    .fetch_rvalid_o (fetch_rvalid_o),
    .aux_req_i      (aux_req_i),
    .aux_addr_i     (aux_addr_i),
    .aux_gnt_o      (aux_gnt_o),
    .aux_rvalid_o   (aux_rvalid_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .rdata_o        (rdata_o),
    .err_o          (err_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, check mid-cycle against the scoreboard, advance.
  // is_src: which requester is expected on the bus this cycle (none when stalled/idle).
  task automatic step(input string tag, input logic fr, input logic ar, input logic g,
                      input logic rv, input logic er, input logic [31:0] rd,
                      input logic [1:0] is_src);
    logic [31:0] exp_addr;
    logic        exp_busy;
    arb_src_e    e;
    fetch_req_i    = fr;
    aux_req_i      = ar;
    instr_gnt_i    = g;
    instr_rvalid_i = rv;
    instr_err_i    = er;
    instr_rdata_i  = rd;
    #3;
    exp_addr = (is_src == IS_F) ? fetch_addr_i : (is_src == IS_A) ? aux_addr_i : 32'h0;
    exp_busy = (exp_q.size() != 0) || (is_src != IS_NONE);
    check({tag, ".req"},  32'(instr_req_o), 32'(is_src != IS_NONE));
    check({tag, ".addr"}, instr_addr_o, exp_addr);
    check({tag, ".fgnt"}, 32'(fetch_gnt_o), 32'(g && is_src == IS_F));
    check({tag, ".agnt"}, 32'(aux_gnt_o), 32'(g && is_src == IS_A));
    check({tag, ".busy"}, 32'(busy_o), 32'(exp_busy));
    check({tag, ".rdata"}, rdata_o, rd);
    check({tag, ".err"}, 32'(err_o), 32'(er));
    if (rv && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, ".frv"}, 32'(fetch_rvalid_o), 32'(e == ARB_SRC_FETCH));
      check({tag, ".arv"}, 32'(aux_rvalid_o), 32'(e == ARB_SRC_AUX));
    end else begin
      check({tag, ".frv"}, 32'(fetch_rvalid_o), 32'h0);
      check({tag, ".arv"}, 32'(aux_rvalid_o), 32'h0);
    end
    if (g && is_src != IS_NONE) begin
      exp_q.push_back((is_src == IS_F) ? ARB_SRC_FETCH : ARB_SRC_AUX);
    end
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [1:0] contend_first();
    return RR ? IS_A : IS_F;
  endfunction

  function automatic logic [1:0] contend_nth(input int n);
    if (!RR) return IS_F;
    return (n % 2 == 0) ? IS_A : IS_F;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni         = 1'b0;
    fetch_req_i    = 1'b0;
    aux_req_i      = 1'b0;
    fetch_addr_i   = 32'h100;
    aux_addr_i     = 32'h200;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b1;
    instr_err_i    = 1'b1;
    instr_rdata_i  = 32'hDEADBEEF;
    #3;
    // Reset state: outputs quiet, data/err pass straight through.
    check("rst.req",   32'(instr_req_o), 32'h0);
    check("rst.addr",  instr_addr_o, 32'h0);
    check("rst.fgnt",  32'(fetch_gnt_o), 32'h0);
    check("rst.agnt",  32'(aux_gnt_o), 32'h0);
    check("rst.frv",   32'(fetch_rvalid_o), 32'h0);
    check("rst.arv",   32'(aux_rvalid_o), 32'h0);
    check("rst.busy",  32'(busy_o), 32'h0);
    check("rst.rdata", rdata_o, 32'hDEADBEEF);
    check("rst.err",   32'(err_o), 32'h1);
    instr_rvalid_i = 1'b0;
    instr_err_i    = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Fetch only, same-cycle grant, response two cycles later.
    fetch_addr_i = 32'h100;
    step("r29a", 1, 0, 1, 0, 0, 32'h1111_0000, IS_F);
    step("r29b", 0, 0, 0, 0, 0, 32'h1111_0001, IS_NONE);
    step("r29c", 0, 0, 0, 1, 0, 32'h0000_0013, IS_NONE);

    // Contention with grant withheld three cycles: selection locked, address held.
    fetch_addr_i = 32'h104;
    aux_addr_i   = 32'h200;
    for (int i = 0; i < 3; i++) step($sformatf("r30w%0d", i), 1, 1, 0, 0, 0, 32'h3000 + i, contend_first());
    step("r30g",  1, 1, 1, 0, 0, 32'h3010, contend_first());
    step("r30n",  1, 1, 1, 0, 0, 32'h3011, IS_F);
    step("r30d1", 0, 0, 0, 1, 0, 32'h3020, IS_NONE);
    step("r30d2", 0, 0, 0, 1, 0, 32'h3021, IS_NONE);

    // Aux locked first keeps the bus even when fetch shows up.
    aux_addr_i = 32'h240;
    step("lk0", 0, 1, 0, 0, 0, 32'h4000, IS_A);
    step("lk1", 1, 1, 0, 0, 0, 32'h4001, IS_A);
    step("lk2", 1, 1, 1, 0, 0, 32'h4002, IS_A);
    step("lk3", 1, 0, 1, 0, 0, 32'h4003, IS_F);
    step("lk4", 0, 0, 0, 1, 1, 32'h4004, IS_NONE);
    step("lk5", 0, 0, 0, 1, 0, 32'h4005, IS_NONE);

    // Saturation at MaxOutstanding: a same-cycle rvalid does not reopen issue.
    fetch_addr_i = 32'h300;
    step("r31a", 1, 0, 1, 0, 0, 32'h5000, IS_F);
    step("r31b", 1, 0, 1, 0, 0, 32'h5001, IS_F);
    step("r31c", 1, 0, 1, 0, 0, 32'h5002, IS_NONE);
    step("r31d", 1, 0, 1, 1, 0, 32'h5003, IS_NONE);
    step("r31e", 1, 0, 1, 0, 0, 32'h5004, IS_F);
    step("r31f", 0, 0, 0, 1, 0, 32'h5005, IS_NONE);
    step("r31g", 0, 0, 0, 1, 0, 32'h5006, IS_NONE);

    // Interleaved F, A, F with error on the aux response.
    fetch_addr_i = 32'h400;
    aux_addr_i   = 32'h500;
    step("r32a", 1, 0, 1, 0, 0, 32'h6000, IS_F);
    step("r32b", 0, 1, 1, 0, 0, 32'h6001, IS_A);
    step("r32c", 1, 0, 1, 1, 0, 32'h6002, IS_NONE);
    step("r32d", 1, 0, 1, 0, 0, 32'h6003, IS_F);
    step("r32e", 0, 0, 0, 1, 1, 32'h6004, IS_NONE);
    step("r32f", 0, 0, 0, 1, 0, 32'h6005, IS_NONE);

    // Reset with two outstanding, then a stray response.
    step("r33a", 1, 0, 1, 0, 0, 32'h7000, IS_F);
    step("r33b", 0, 1, 1, 0, 0, 32'h7001, IS_A);
    fetch_req_i = 1'b0;
    aux_req_i   = 1'b0;
    instr_gnt_i = 1'b0;
    rst_ni      = 1'b0;
    #3;
    check("r33r.busy", 32'(busy_o), 32'h0);
    check("r33r.req",  32'(instr_req_o), 32'h0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    exp_q.delete();
    step("r33s", 0, 0, 0, 1, 0, 32'h7002, IS_NONE);

    // Continuous contention for four grants.
    fetch_addr_i = 32'h600;
    aux_addr_i   = 32'h700;
    step("r34a", 1, 1, 1, 0, 0, 32'h8000, contend_nth(0));
    step("r34b", 1, 1, 1, 0, 0, 32'h8001, contend_nth(1));
    step("r34c", 1, 1, 1, 1, 0, 32'h8002, IS_NONE);
    step("r34d", 1, 1, 1, 1, 0, 32'h8003, contend_nth(2));
    step("r34e", 1, 1, 1, 1, 0, 32'h8004, contend_nth(3));
    step("r34f", 0, 0, 0, 1, 0, 32'h8005, IS_NONE);
    step("idle", 0, 0, 0, 0, 0, 32'h8006, IS_NONE);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ibex_instr_bus_arbiter.md
IBEX_INSTR_BUS_ARBITER -- requirements
Module: ibex_instr_bus_arbiter

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2, meaning the maximum number of granted requests awaiting rvalid (range 1..4).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports fetch_req_i (input, 1), fetch_addr_i (input, 32), fetch_gnt_o (output, 1), fetch_rvalid_o (output, 1): the prefetch/icache requester.
REQ-005 SHALL have ports aux_req_i (input, 1), aux_addr_i (input, 32), aux_gnt_o (output, 1), aux_rvalid_o (output, 1): the auxiliary requester (debug program buffer or scrubber).
REQ-006 SHALL have ports instr_req_o (output, 1), instr_addr_o (output, 32), instr_gnt_i (input, 1), instr_rvalid_i (input, 1): the shared instruction bus.
REQ-007 SHALL have ports rdata_o (output, 32) and err_o (output, 1): instr_rdata_i and instr_err_i broadcast to both requesters.
REQ-008 SHALL have port busy_o (output, 1): high while the outstanding count is non-zero or instr_req_o is high.

Function
REQ-009 SHALL drive instr_req_o high when the selected requester's req is high and the outstanding count < MaxOutstanding.
REQ-010 SHALL drive instr_addr_o from the selected requester, and SHALL drive it to 0 when instr_req_o is low.
REQ-011 SHALL assert gnt combinationally only to the selected requester: fetch_gnt_o = instr_req_o & instr_gnt_i & sel==FETCH, and likewise for aux.
REQ-012 SHALL lock the selection (lock_q=1) in any cycle with instr_req_o & ~instr_gnt_i, and SHALL hold the selection while locked; lock_q clears on grant.
REQ-013 When unlocked and only one requester is requesting, SHALL select that requester.
REQ-014 When unlocked and both request, SHALL arbitrate per REQ-024/REQ-025.
REQ-015 On each grant, SHALL push the granted source ID into the outstanding FIFO; on instr_rvalid_i, SHALL pop the head and raise the rvalid output of that source for that cycle only.
REQ-016 Push and pop in the same cycle SHALL leave the count unchanged.
REQ-017 At count == MaxOutstanding, SHALL hold instr_req_o low even if instr_rvalid_i is high in that cycle; a locked selection SHALL remain locked while stalled.
REQ-018 Downstream responses SHALL return in order; rvalid and err SHALL have zero-cycle latency to the requester.
REQ-019 instr_rvalid_i with an empty FIFO SHALL be ignored (both rvalid outputs low) and SHALL be flagged by assertion.

Reset
REQ-020 SHALL reset asynchronously on rst_ni low: FIFO count 0, lock_q 0, selection FETCH, round-robin pointer FETCH.
REQ-021 After reset, all outputs SHALL be 0 until a request arrives; rdata_o and err_o SHALL follow the inputs.
REQ-022 Reset asserted mid-transaction SHALL discard all outstanding IDs; late rvalids after reset fall under REQ-019.

Configuration
REQ-023 Macro IBEX_INSTR_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-024 With the macro defined: on contention, SHALL grant the requester not granted most recently; the pointer updates on each grant.
REQ-025 Without the macro: fixed priority, fetch always wins; the pointer flop SHALL NOT be instantiated.

Structure
REQ-026 Enum arb_src_e {ARB_SRC_FETCH, ARB_SRC_AUX} SHALL reside in ibex_pkg.
REQ-027 The outstanding-ID queue SHALL be a sub-module, ibex_instr_arb_id_fifo (depth MaxOutstanding, 1-bit entries, push/pop/full/empty).
REQ-028 SHALL include assertions: address stable and req held while locked; no rvalid without an outstanding ID; both gnt outputs never high together.

Verification
REQ-029 Fetch only: req at 0x100 with gnt on the same cycle, rvalid 2 cycles later -> fetch_gnt_o=1 the same cycle, fetch_rvalid_o=1 with rdata 0x00000013, aux signals 0.
REQ-030 Both request, gnt held low 3 cycles: aux at 0x200 selected under RR (pointer=FETCH) -> instr_addr_o=0x200 stable for 4 cycles, then aux_gnt_o, then fetch served next.
REQ-031 Fill to MaxOutstanding=2 with no rvalid: third request -> instr_req_o=0; rvalid in that cycle -> still 0; request issued the following cycle.
REQ-032 Interleaved grants F,A,F then three rvalids with err on the 2nd -> rvalid order fetch, aux(err_o=1), fetch.
REQ-033 rst_ni pulsed low with 2 outstanding, then a stray rvalid -> both rvalid outputs 0, busy_o=0, assertion fires.
REQ-034 Without the macro, both requesting continuously for 4 grants -> all four go to fetch, aux_gnt_o never asserted.
